// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan driver: conversion FSM states,
// seven-segment codes and display limits.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [13:0] COUNT_MAX  = 14'd9999;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    // Active-low segments, bit 7 = dp (always off), bits 6:0 = g..a
    localparam logic [7:0] SEG_CODES [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_CODES[digit];
        end
        return SEG_BLANK;
    endfunction

    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble converter: 14-bit binary to four BCD nibbles,
// one shift per clock, fourteen shifts per conversion.
module bin2bcd_serial
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    conv_state_e state_q;
    logic [3:0]  iter_q;
    logic [29:0] shift_q;
    logic [15:0] bcd_adj;
    logic [29:0] shift_d;

    // Upper 16 bits are the BCD accumulator, lower 14 the binary being consumed
    always_comb begin
        bcd_adj = {dabble_adjust(shift_q[29:26]), dabble_adjust(shift_q[25:22]),
                   dabble_adjust(shift_q[21:18]), dabble_adjust(shift_q[17:14])};
        shift_d = {bcd_adj[14:0], shift_q[13:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            iter_q  <= 4'd0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shift_q <= {16'd0, bin_i};
                        iter_q  <= 4'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    if (iter_q == 4'd13) begin
                        state_q <= DONE;
                    end else begin
                        iter_q <= iter_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign bcd_o  = shift_q[29:14];

endmodule

// File: rtl/fnd_scan_driver.sv
// Converts the counter value to BCD and time-multiplexes it onto a 4-digit
// common-anode display with optional leading-zero blanking.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [13:0]           count,
    output logic                  conv_busy,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [13:0]           count_sat;
    logic [13:0]           last_val_q;
    logic [15:0]           digits_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [7:0]            data_q, data_d;
    logic                  conv_start;
    logic                  conv_done;
    logic [15:0]           conv_bcd;
    logic [3:0]            cur_digit;
    logic [3:0]            blank;
    logic                  thou_zero, hund_zero, tens_zero;

    assign count_sat  = (count > COUNT_MAX) ? COUNT_MAX : count;
    assign conv_start = !conv_busy && (count_sat != last_val_q);

    bin2bcd_serial u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (count_sat),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_digit = digits_q[3:0];
            2'd1:    cur_digit = digits_q[7:4];
            2'd2:    cur_digit = digits_q[11:8];
            default: cur_digit = digits_q[15:12];
        endcase
    end

    // A higher digit is only blanked if every digit above it is also zero
    always_comb begin
        thou_zero = (digits_q[15:12] == 4'd0);
        hund_zero = (digits_q[11:8] == 4'd0);
        tens_zero = (digits_q[7:4] == 4'd0);
        blank[0]  = 1'b0;
        blank[1]  = BLANK_LZ && thou_zero && hund_zero && tens_zero;
        blank[2]  = BLANK_LZ && thou_zero && hund_zero;
        blank[3]  = BLANK_LZ && thou_zero;
        com_d     = ~(NUM_DIGITS'(1) << idx_q);
        data_d    = blank[idx_q] ? SEG_BLANK : seg_code(cur_digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_val_q <= 14'd0;
            digits_q   <= 16'd0;
            div_q      <= '0;
            idx_q      <= 2'd0;
            com_q      <= '1;
            data_q     <= SEG_BLANK;
        end else begin
            if (conv_start) begin
                last_val_q <= count_sat;
            end
            if (conv_done) begin
                digits_q <= conv_bcd;
            end
            div_q  <= div_d;
            idx_q  <= idx_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: two instances (blanking on/off) share
// stimulus; frames are captured by digit enable and compared to hand values.
module tb_fnd_scan_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] count = 14'd0;

    logic       busyA, busyB;
    logic [3:0] comA, comB;
    logic [7:0] dataA, dataB;

    logic [7:0] frameA [4];
    logic [7:0] frameB [4];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .conv_busy (busyA),
        .fnd_com   (comA),
        .fnd_data  (dataA)
    );

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nolz (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .conv_busy (busyB),
        .fnd_com   (comB),
        .fnd_data  (dataB)
    );

    // Record the segment byte shown for each digit over one full frame
    task automatic capture_frame();
        for (int d = 0; d < 4; d++) begin
            frameA[d] = 8'h00;
            frameB[d] = 8'h00;
        end
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (comA == 4'(~(4'b0001 << d))) frameA[d] = dataA;
                if (comB == 4'(~(4'b0001 << d))) frameB[d] = dataB;
            end
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busyA && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [3:0] expCom;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (comA !== 4'b1111 || dataA !== 8'hFF || busyA !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state com=%b data=%h busy=%b expected 1111/ff/0", comA, dataA, busyA);
        end
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expCom = 4'(~(4'b0001 << (k / 4)));
            tests_run++;
            if (comA !== expCom || comB !== expCom) begin
                tests_failed++;
                $display("[TB] FAIL scan_com cycle %0d got %b/%b expected %b", k, comA, comB, expCom);
            end
            tests_run++;
            if (dataA !== ((k < 4) ? 8'hC0 : 8'hFF) || dataB !== 8'hC0) begin
                tests_failed++;
                $display("[TB] FAIL scan_zero_data cycle %0d got %h/%h", k, dataA, dataB);
            end
            tests_run++;
            if (busyA !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_busy cycle %0d got %b expected 0", k, busyA);
            end
        end
    endtask

    task automatic test_convert(input logic [13:0] value, input logic [7:0] expA [4],
                                input logic [7:0] expB [4], input string name);
        int n;
        @(negedge clk);
        count = value;
        @(negedge clk);
        tests_run++;
        if (busyA !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_start busy=%b expected 1", name, busyA);
        end
        wait_busy(n);
        tests_run++;
        if (n != 15) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_len got %0d cycles expected 15", name, n);
        end
        capture_frame();
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (frameA[d] !== expA[d] || frameB[d] !== expB[d]) begin
                tests_failed++;
                $display("[TB] FAIL %s_digit%0d got %h/%h expected %h/%h",
                         name, d, frameA[d], frameB[d], expA[d], expB[d]);
            end
        end
    endtask

    task automatic test_values();
        logic [7:0] eA [4];
        logic [7:0] eB [4];
        eA = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        eB = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        test_convert(14'd1234, eA, eB, "v1234");
        eA = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
        eB = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
        test_convert(14'd7, eA, eB, "v7");
        eA = '{8'h90, 8'h90, 8'h90, 8'h90};
        eB = '{8'h90, 8'h90, 8'h90, 8'h90};
        test_convert(14'd16383, eA, eB, "sat");
    endtask

    task automatic test_saturated_no_change();
        int seen = 0;
        @(negedge clk);
        count = 14'd10000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busyA) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL sat_no_reconvert busy seen %0d cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int seen = 0;
        @(negedge clk);
        count = 14'd100;
        @(negedge clk);
        repeat (4) @(negedge clk);
        count = 14'd205;
        repeat (3) @(negedge clk);
        count = 14'd9;
        wait_busy(n);
        tests_run++;
        if (n != 8) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_tail got %0d cycles expected 8", n);
        end
        @(negedge clk);
        tests_run++;
        if (busyA !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_restart busy=%b expected 1", busyA);
        end
        wait_busy(n);
        tests_run++;
        if (n != 15) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_len got %0d cycles expected 15", n);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busyA) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_no_third busy seen %0d cycles expected 0", seen);
        end
        capture_frame();
        tests_run++;
        if (frameA[0] !== 8'h90 || frameA[1] !== 8'hFF || frameA[2] !== 8'hFF || frameA[3] !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL b2b_final_lz got %h %h %h %h expected 90 ff ff ff",
                     frameA[0], frameA[1], frameA[2], frameA[3]);
        end
        tests_run++;
        if (frameB[0] !== 8'h90 || frameB[1] !== 8'hC0 || frameB[2] !== 8'hC0 || frameB[3] !== 8'hC0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_final_nolz got %h %h %h %h expected 90 c0 c0 c0",
                     frameB[0], frameB[1], frameB[2], frameB[3]);
        end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        @(negedge clk);
        count = 14'd4321;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (comA !== 4'b1111 || dataA !== 8'hFF || busyA !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset com=%b data=%h busy=%b expected 1111/ff/0", comA, dataA, busyA);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (comA !== 4'b1110 || dataA !== 8'hC0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_display com=%b data=%h expected 1110/c0", comA, dataA);
        end
        tests_run++;
        if (busyA !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_restart busy=%b expected 1", busyA);
        end
        wait_busy(n);
        tests_run++;
        if (n != 15) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_len got %0d cycles expected 15", n);
        end
        capture_frame();
        tests_run++;
        if (frameA[0] !== 8'hF9 || frameA[1] !== 8'hA4 || frameA[2] !== 8'hB0 || frameA[3] !== 8'h99) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_frame got %h %h %h %h expected f9 a4 b0 99",
                     frameA[0], frameA[1], frameA[2], frameA[3]);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_saturated_no_change();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
